multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 31 +++
 rtl/multicycle_control.sv | 136 +++++++++++++
 tb/tb_multicycle_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/memories.
// The slave side is the controller; the master side drives opcode and memory readiness.
interface multicycle_control_if;
    logic [6:0]  opcode;
    logic        imem_ready;
    logic        dmem_ready;
    logic        ir_write;
    logic        pc_write;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_write;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] instr_count;

    modport master (
        output opcode, imem_ready, dmem_ready,
        input  ir_write, pc_write, branch, mem_read, mem_write, mem_to_reg,
               alu_src, reg_write, alu_op, state, fault, instr_count
    );

    modport slave (
        input  opcode, imem_ready, dmem_ready,
        output ir_write, pc_write, branch, mem_read, mem_write, mem_to_reg,
               alu_src, reg_write, alu_op, state, fault, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM (R/load/store/branch) with handshake timeouts,
// a sticky fault state and a retired-instruction counter.
module multicycle_control #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_control_if.slave bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100,
        FAULT  = 3'b111
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [6:0]  op_q;
    logic [7:0]  wait_q;
    logic [31:0] cnt_q;
    logic        wait_inc;
    logic        ir_w, pc_w, br, mr, mw, m2r, as, rw;
    logic [1:0]  aop;

    always_comb begin
        state_d  = state_q;
        wait_inc = 1'b0;
        ir_w     = 1'b0;
        pc_w     = 1'b0;
        br       = 1'b0;
        mr       = 1'b0;
        mw       = 1'b0;
        m2r      = 1'b0;
        as       = 1'b0;
        rw       = 1'b0;
        aop      = 2'b00;
        case (state_q)
            FETCH: begin
                ir_w = bus.imem_ready;
                if (bus.imem_ready) begin
                    state_d = DECODE;
                end else begin
                    wait_inc = 1'b1;
                    if (wait_q == WAIT_MAX) state_d = FAULT;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_R, OP_LOAD, OP_STORE, OP_BRANCH: state_d = EXEC;
                    default:                            state_d = FAULT;
                endcase
            end
            EXEC: begin
                case (op_q)
                    OP_R: begin
                        aop     = 2'b10;
                        state_d = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        as      = 1'b1;
                        state_d = MEM;
                    end
                    OP_BRANCH: begin
                        aop     = 2'b01;
                        br      = 1'b1;
                        pc_w    = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = FAULT;
                endcase
            end
            MEM: begin
                as = 1'b1;
                if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    mr = (op_q == OP_LOAD);
                    mw = (op_q == OP_STORE);
                    if (bus.dmem_ready) begin
                        // Store retires here; load still needs write-back.
                        pc_w    = mw;
                        state_d = mr ? WB : FETCH;
                    end else begin
                        wait_inc = 1'b1;
                        if (wait_q == WAIT_MAX) state_d = FAULT;
                    end
                end else begin
                    state_d = FAULT;
                end
            end
            WB: begin
                rw      = 1'b1;
                pc_w    = 1'b1;
                m2r     = (op_q == OP_LOAD);
                state_d = FETCH;
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= 7'd0;
            wait_q  <= 8'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) op_q <= bus.opcode;
            if (state_d != state_q)  wait_q <= 8'd0;
            else if (wait_inc)       wait_q <= wait_q + 8'd1;
            if (pc_w) cnt_q <= cnt_q + 32'd1;
        end
    end

    // Everything but ir_write is forced low while reset is held, whatever the old state.
    assign bus.ir_write    = ir_w;
    assign bus.pc_write    = reset ? 1'b0 : pc_w;
    assign bus.branch      = reset ? 1'b0 : br;
    assign bus.mem_read    = reset ? 1'b0 : mr;
    assign bus.mem_write   = reset ? 1'b0 : mw;
    assign bus.mem_to_reg  = reset ? 1'b0 : m2r;
    assign bus.alu_src     = reset ? 1'b0 : as;
    assign bus.reg_write   = reset ? 1'b0 : rw;
    assign bus.alu_op      = reset ? 2'b00 : aop;
    assign bus.state       = reset ? 3'b000 : state_q;
    assign bus.fault       = reset ? 1'b0 : (state_q == FAULT);
    assign bus.instr_count = reset ? 32'd0 : cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: an instruction-level model expands each instruction into its
// expected per-cycle trace, which is then replayed against the controller.
module tb_multicycle_control;
    localparam int TO = 16;

    localparam logic [2:0] S_F = 3'b000, S_D = 3'b001, S_E = 3'b010,
                           S_M = 3'b011, S_W = 3'b100, S_X = 3'b111;
    localparam logic [7:0] IRW = 8'h80, PCW = 8'h40, BR = 8'h20, MR = 8'h10,
                           MW  = 8'h08, M2R = 8'h04, AS = 8'h02, RW = 8'h01;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        ir;
        logic        dr;
        logic [13:0] exp;
        logic [31:0] cnt;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;
    multicycle_control_if bus();

    multicycle_control #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    cyc_t        q[$];
    logic [31:0] mcnt;
    int          n_chk = 0, n_err = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [13:0] cv(input logic [2:0] st, input logic [7:0] f,
                                       input logic [1:0] aop, input logic flt);
        return {st, f, aop, flt};
    endfunction

    function automatic logic [6:0] op_of(input int k);
        case (k)
            0:       return 7'b0110011;
            1:       return 7'b0000011;
            2:       return 7'b0100011;
            default: return 7'b1100011;
        endcase
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    task automatic push(input logic rst, input logic [6:0] op, input logic ir,
                        input logic dr, input logic [13:0] e);
        cyc_t c;
        c.rst = rst; c.op = op; c.ir = ir; c.dr = dr; c.exp = e;
        c.cnt = rst ? 32'd0 : mcnt;
        q.push_back(c);
        if (rst)       mcnt = 32'd0;
        else if (e[9]) mcnt = mcnt + 32'd1;
    endtask

    task automatic add_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b1, r7(), 1'b0, r1(), 14'd0);
    endtask

    task automatic add_fault(input int n);
        for (int i = 0; i < n; i++) push(1'b0, r7(), r1(), r1(), cv(S_X, 8'h00, 2'b00, 1'b1));
    endtask

    // k: 0=R 1=load 2=store 3=branch; di/dd: cycles of not-ready before the handshake.
    task automatic add_instr(input int k, input int di, input int dd, output bit died);
        logic [7:0] mem_f;
        died = 1'b0;
        for (int i = 0; i < di && i < TO; i++) push(1'b0, r7(), 1'b0, r1(), cv(S_F, 8'h00, 2'b00, 1'b0));
        if (di >= TO) begin
            died = 1'b1;
            return;
        end
        push(1'b0, r7(), 1'b1, r1(), cv(S_F, IRW, 2'b00, 1'b0));
        push(1'b0, op_of(k), r1(), r1(), cv(S_D, 8'h00, 2'b00, 1'b0));
        case (k)
            0:       push(1'b0, r7(), r1(), r1(), cv(S_E, 8'h00, 2'b10, 1'b0));
            3:       push(1'b0, r7(), r1(), r1(), cv(S_E, BR | PCW, 2'b01, 1'b0));
            default: push(1'b0, r7(), r1(), r1(), cv(S_E, AS, 2'b00, 1'b0));
        endcase
        if (k == 1 || k == 2) begin
            mem_f = (k == 1) ? (MR | AS) : (MW | AS);
            for (int i = 0; i < dd && i < TO; i++) push(1'b0, r7(), r1(), 1'b0, cv(S_M, mem_f, 2'b00, 1'b0));
            if (dd >= TO) begin
                died = 1'b1;
                return;
            end
            push(1'b0, r7(), r1(), 1'b1, cv(S_M, (k == 2) ? (mem_f | PCW) : mem_f, 2'b00, 1'b0));
        end
        if (k == 0) push(1'b0, r7(), r1(), r1(), cv(S_W, RW | PCW, 2'b00, 1'b0));
        if (k == 1) push(1'b0, r7(), r1(), r1(), cv(S_W, RW | PCW | M2R, 2'b00, 1'b0));
    endtask

    initial begin
        bit         d;
        logic [6:0] bad;
        logic [13:0] got;
        mcnt = 32'd0;

        add_reset(2);
        add_instr(0, 0, 0, d);
        add_instr(1, 0, 3, d);
        for (int i = 0; i < 3; i++) add_instr(3, 0, 0, d);
        add_instr(0, TO - 1, 0, d);
        add_instr(2, 0, TO - 1, d);
        add_instr(1, 1, TO - 1, d);
        for (int i = 0; i < 60; i++) begin
            int k, di, dd;
            k  = $urandom_range(0, 3);
            di = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
            dd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
            add_instr(k, di, dd, d);
        end

        // store interrupted by reset while waiting in MEM
        push(1'b0, r7(), 1'b1, r1(), cv(S_F, IRW, 2'b00, 1'b0));
        push(1'b0, op_of(2), r1(), r1(), cv(S_D, 8'h00, 2'b00, 1'b0));
        push(1'b0, r7(), r1(), r1(), cv(S_E, AS, 2'b00, 1'b0));
        push(1'b0, r7(), r1(), 1'b0, cv(S_M, MW | AS, 2'b00, 1'b0));
        push(1'b0, r7(), r1(), 1'b0, cv(S_M, MW | AS, 2'b00, 1'b0));
        add_reset(1);
        add_instr(3, 0, 0, d);

        // illegal opcode
        do bad = r7();
        while (bad == 7'b0110011 || bad == 7'b0000011 || bad == 7'b0100011 || bad == 7'b1100011);
        push(1'b0, r7(), 1'b1, r1(), cv(S_F, IRW, 2'b00, 1'b0));
        push(1'b0, bad, r1(), r1(), cv(S_D, 8'h00, 2'b00, 1'b0));
        add_fault(10);
        add_reset(1);
        push(1'b0, r7(), 1'b1, r1(), cv(S_F, IRW, 2'b00, 1'b0));
        push(1'b0, 7'b1111111, r1(), r1(), cv(S_D, 8'h00, 2'b00, 1'b0));
        add_fault(10);
        add_reset(1);

        add_instr(0, TO, 0, d);
        add_fault(4);
        add_reset(1);
        add_instr(1, 0, TO, d);
        add_fault(3);
        add_reset(1);
        add_instr(2, 0, 0, d);
        add_instr(0, 0, 0, d);

        foreach (q[i]) begin
            cyc            = i;
            reset          = q[i].rst;
            bus.opcode     = q[i].op;
            bus.imem_ready = q[i].ir;
            bus.dmem_ready = q[i].dr;
            @(negedge clk);
            got = {bus.state, bus.ir_write, bus.pc_write, bus.branch, bus.mem_read,
                   bus.mem_write, bus.mem_to_reg, bus.alu_src, bus.reg_write,
                   bus.alu_op, bus.fault};
            chk("ctl", {18'd0, got}, {18'd0, q[i].exp});
            chk("instr_count", bus.instr_count, q[i].cnt);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
